spi_xfer_ctrl: RTL

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/sdio_spi_pkg.sv | 24 ++
 rtl/spi_xfer_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sdio_spi_pkg.sv
// Shared definitions for the SDIO-over-SPI bridge: transfer FSM encoding,
// default command codes and the filler byte.
package sdio_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StLen,
    StWdata,
    StRdata,
    StDrain
  } xfer_state_e;

  localparam logic [7:0] DefCmdWr    = 8'h01;
  localparam logic [7:0] DefCmdRd    = 8'h02;
  localparam logic [7:0] DefCmdSt    = 8'h03;
  localparam logic [7:0] DefIdleByte = 8'hFF;

  // A length byte of zero encodes a full 256-byte burst.
  function automatic logic [8:0] len_decode(input logic [7:0] len_byte);
    return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: decodes command/length bytes from the SPI slave and
// moves burst data between the shifter and the rx/tx FIFOs.
module spi_xfer_ctrl
  import sdio_spi_pkg::*;
#(
  parameter logic [7:0] CMD_WR    = DefCmdWr,
  parameter logic [7:0] CMD_RD    = DefCmdRd,
  parameter logic [7:0] CMD_ST    = DefCmdSt,
  parameter logic [7:0] IDLE_BYTE = DefIdleByte
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SSEL,
  input  logic [7:0] spi_data_o,
  input  logic       spi_rxdy,
  input  logic       spi_txcomp,
  output logic [7:0] spi_data_i,
  output logic       wr_en,
  output logic [7:0] wr_data,
  input  logic       wr_full,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  input  logic       rd_empty,
  input  logic       err_clr,
  output logic       busy,
  output logic       ovf_err,
  output logic       unf_err
);

  xfer_state_e state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [8:0]  count_q, count_d;
  logic [8:0]  rd_cnt;
  logic [7:0]  spi_tx_d, wr_data_d;
  logic        wr_en_d, rd_en_d;
  logic        ovf_set, unf_set, load_rd;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    count_d   = count_q;
    spi_tx_d  = spi_data_i;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data;
    rd_en_d   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    load_rd   = 1'b0;
    rd_cnt    = count_q;

    // Deselect aborts any burst and overrides same-cycle rxdy/txcomp.
    if (state_q != StIdle && SSEL) begin
      state_d  = StIdle;
      count_d  = '0;
      spi_tx_d = IDLE_BYTE;
    end else begin
      unique case (state_q)
        StIdle: begin
          spi_tx_d = IDLE_BYTE;
          if (!SSEL) state_d = StCmd;
        end
        StCmd: begin
          if (spi_rxdy) begin
            cmd_d = spi_data_o;
            if (spi_data_o == CMD_WR || spi_data_o == CMD_RD) begin
              state_d = StLen;
            end else if (spi_data_o == CMD_ST) begin
              spi_tx_d = {4'b0000, unf_err, ovf_err, rd_empty, wr_full};
              state_d  = StDrain;
            end else begin
              state_d = StDrain;
            end
          end
        end
        StLen: begin
          if (spi_rxdy) begin
            count_d = len_decode(spi_data_o);
            if (cmd_q == CMD_RD) begin
              rd_cnt  = len_decode(spi_data_o);
              load_rd = 1'b1;
            end else begin
              state_d = StWdata;
            end
          end
        end
        StWdata: begin
          if (spi_rxdy) begin
            if (!wr_full) begin
              wr_en_d   = 1'b1;
              wr_data_d = spi_data_o;
            end else begin
              ovf_set = 1'b1;
            end
            count_d = count_q - 9'd1;
            if (count_q == 9'd1) state_d = StDrain;
          end
        end
        StRdata: begin
          if (spi_txcomp) load_rd = 1'b1;
        end
        StDrain: begin
          if (spi_txcomp) spi_tx_d = IDLE_BYTE;
        end
        default: state_d = StIdle;
      endcase

      if (load_rd) begin
        if (!rd_empty) begin
          spi_tx_d = rd_data;
          rd_en_d  = 1'b1;
        end else begin
          spi_tx_d = IDLE_BYTE;
          unf_set  = 1'b1;
        end
        count_d = rd_cnt - 9'd1;
        state_d = (rd_cnt == 9'd1) ? StDrain : StRdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      count_q    <= '0;
      spi_data_i <= IDLE_BYTE;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      rd_en      <= 1'b0;
      ovf_err    <= 1'b0;
      unf_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      count_q    <= count_d;
      spi_data_i <= spi_tx_d;
      wr_en      <= wr_en_d;
      wr_data    <= wr_data_d;
      rd_en      <= rd_en_d;
      // A new error in the clearing cycle keeps the flag set.
      ovf_err    <= ovf_set | (ovf_err & ~err_clr);
      unf_err    <= unf_set | (unf_err & ~err_clr);
      busy       <= (state_d != StIdle);
    end
  end

endmodule
